sevenseg_scan_driver: RTL

//   Time-multiplexed 7-segment display driver. Sits directly downstream of the
//   BCD digit counters (mod-6 / mod-10 chain) and consumes their Q outputs.

---
 rtl/sevenseg_pkg.sv | 46 ++++
 rtl/hex7seg_decode.sv | 11 +
 rtl/sevenseg_scan_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Segment patterns and hex-to-7-segment helper shared by the scan driver.
// Bit order is {g,f,e,d,c,b,a}, active-high.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to active-high 7-segment pattern.
module hex7seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex7(hex);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 7-segment scanner: per-frame digit snapshot, guard band per slot,
// leading-zero blanking and per-digit blink. All outputs are registered.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int LZB_EN       = 1,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // XOR masks: also the "everything off" levels for each output
    localparam logic [6:0]          SEG_POL = {7{SEG_ACT_LOW != 0}};
    localparam logic                DP_POL  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{AN_ACT_LOW != 0}};

    logic [PW-1:0]                pcnt_q, pcnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]     dig_snap_q, dig_snap_d;
    logic [N_DIGITS-1:0]          dp_snap_q, dp_snap_d;
    logic [N_DIGITS-1:0]          blk_snap_q, blk_snap_d;
    logic [BW-1:0]                blink_cnt_q, blink_cnt_d;
    logic                         blink_phase_q, blink_phase_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         dp_q, dp_d;
    logic [N_DIGITS-1:0]          an_q, an_d;
    logic                         frame_tick_q, frame_tick_d;

    logic                slot_end, frame_wrap, blank;
    logic [3:0]          cur_digit;
    logic [6:0]          seg_raw;
    logic [N_DIGITS-1:0] zero_from, an_raw;

    assign slot_end   = (pcnt_q == PW'(REFRESH_DIV - 1));
    assign frame_wrap = slot_end && (idx_q == IW'(N_DIGITS - 1));
    assign cur_digit  = dig_snap_q[idx_q];

    hex7seg_decode u_dec (
        .hex (cur_digit),
        .seg (seg_raw)
    );

    // zero_from[i]: snapshot digits i..N_DIGITS-1 are all zero
    always_comb begin
        zero_from = '0;
        zero_from[N_DIGITS-1] = (dig_snap_q[N_DIGITS-1] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (dig_snap_q[i] == 4'd0);
    end

    always_comb begin
        pcnt_d        = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d         = idx_q;
        dig_snap_d    = dig_snap_q;
        dp_snap_d     = dp_snap_q;
        blk_snap_d    = blk_snap_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_end)
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        if (frame_wrap) begin
            dig_snap_d = digits_in;
            dp_snap_d  = dp_in;
            blk_snap_d = blink_mask;
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Blanked digits keep their anode slot so brightness stays uniform
        blank = (blk_snap_q[idx_q] && blink_phase_q) ||
                ((LZB_EN != 0) && (idx_q != '0) && zero_from[idx_q]);
        an_raw = '0;
        if (pcnt_q >= PW'(GUARD_CYCLES))
            an_raw[idx_q] = 1'b1;

        seg_d        = (blank ? SEG_OFF : seg_raw) ^ SEG_POL;
        dp_d         = (!blank && dp_snap_q[idx_q]) ^ DP_POL;
        an_d         = an_raw ^ AN_POL;
        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            dig_snap_q    <= '0;
            dp_snap_q     <= '0;
            blk_snap_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_POL;
            dp_q          <= DP_POL;
            an_q          <= AN_POL;
            frame_tick_q  <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            dig_snap_q    <= dig_snap_d;
            dp_snap_q     <= dp_snap_d;
            blk_snap_q    <= blk_snap_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
